// File: rtl/fib_request_scheduler.sv
// fib_request_scheduler
// Round-robin front end that shares one iterative Fibonacci datapath
// (two registers a/b, one W-bit adder) among N_REQ requesters.
//
// Handshakes: a transfer happens on a clock edge where valid and ready
// are both high. req_ready is combinational and may only rise in IDLE;
// rsp_valid is registered and the response fields hold steady until
// rsp_ready is seen high on an edge.
//
// Build option: define FIB_LAST_CACHE_EN to keep the last computed
// {index, data, overflow} and answer a repeated index without stepping.
module fib_request_scheduler #(
  parameter int N_REQ = 2,
  parameter int W     = 16,
  parameter int IDX_W = 6
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*IDX_W-1:0]     req_index,
  output logic [N_REQ-1:0]           req_ready,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [W-1:0]               rsp_data,
  output logic [$clog2(N_REQ)-1:0]   rsp_id,
  output logic                       rsp_overflow,
  output logic                       busy
);

  localparam int ID_W = $clog2(N_REQ);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] COMPUTE = 2'd1;
  localparam logic [1:0] RESPOND = 2'd2;

  logic [1:0]       state;
  logic [ID_W-1:0]  ptr;
  logic [ID_W-1:0]  id_q;
  logic [IDX_W-1:0] cnt;
  logic [W-1:0]     a, b;
  logic             a_ovf, b_ovf;
  logic [W:0]       sum;

  logic [N_REQ-1:0] grant;
  logic [ID_W-1:0]  grant_id;
  logic             found;
  int               j;
  logic             accept;
  logic [IDX_W-1:0] sel_idx;
  logic [ID_W-1:0]  ptr_next;

  logic             cache_hit;
  logic [W-1:0]     hit_data;
  logic             hit_ovf;

  // Round-robin pick: first valid requester at or after ptr, wrapping.
  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    j        = 0;
    for (int k = 0; k < N_REQ; k++) begin
      j = (int'(ptr) + k) % N_REQ;
      if (!found && req_valid[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        grant_id = ID_W'(j);
      end
    end
  end

  // Grants are only offered in IDLE and never on a reset cycle.
  assign req_ready = (state == IDLE && !rst) ? grant : '0;
  assign accept    = found && state == IDLE && !rst;
  assign sel_idx   = req_index[int'(grant_id)*IDX_W +: IDX_W];
  assign ptr_next  = (int'(grant_id) == N_REQ - 1) ? '0 : grant_id + 1'b1;
  assign sum       = {1'b0, a} + {1'b0, b};

  // The response fields are the datapath registers themselves: they only
  // change in IDLE/COMPUTE, so they are frozen for the whole RESPOND state.
  assign rsp_valid    = (state == RESPOND);
  assign rsp_data     = a;
  assign rsp_id       = id_q;
  assign rsp_overflow = a_ovf;
  assign busy         = (state != IDLE);

`ifdef FIB_LAST_CACHE_EN
  logic             cache_valid;
  logic [IDX_W-1:0] cache_idx;
  logic [W-1:0]     cache_data;
  logic             cache_ovf;
  logic [IDX_W-1:0] idx_q;

  assign cache_hit = cache_valid && (cache_idx == sel_idx);
  assign hit_data  = cache_data;
  assign hit_ovf   = cache_ovf;

  // Remember the index in flight and capture the result as the last step lands.
  always_ff @(posedge clk) begin
    if (rst) begin
      cache_valid <= 1'b0;
      cache_idx   <= '0;
      cache_data  <= '0;
      cache_ovf   <= 1'b0;
      idx_q       <= '0;
    end else begin
      if (accept) idx_q <= sel_idx;
      if (state == COMPUTE && cnt == IDX_W'(1)) begin
        cache_valid <= 1'b1;
        cache_idx   <= idx_q;
        cache_data  <= b;
        cache_ovf   <= b_ovf;
      end
    end
  end
`else
  assign cache_hit = 1'b0;
  assign hit_data  = '0;
  assign hit_ovf   = 1'b0;
`endif

  // Control FSM plus the shared two-register Fibonacci datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= '0;
      id_q  <= '0;
      cnt   <= '0;
      a     <= '0;
      b     <= '0;
      a_ovf <= 1'b0;
      b_ovf <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            id_q  <= grant_id;
            ptr   <= ptr_next;
            cnt   <= sel_idx;
            b     <= W'(1);
            b_ovf <= 1'b0;
            if (cache_hit) begin
              a     <= hit_data;
              a_ovf <= hit_ovf;
              state <= RESPOND;
            end else begin
              a     <= '0;
              a_ovf <= 1'b0;
              state <= (sel_idx == '0) ? RESPOND : COMPUTE;
            end
          end
        end
        COMPUTE: begin
          a     <= b;
          b     <= sum[W-1:0];
          a_ovf <= b_ovf;
          b_ovf <= b_ovf | sum[W];
          cnt   <= cnt - 1'b1;
          if (cnt == IDX_W'(1)) state <= RESPOND;
        end
        RESPOND: begin
          if (rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fib_request_scheduler.sv
// tb_fib_request_scheduler
// Directed bench for fib_request_scheduler (N_REQ=2, W=16, IDX_W=6).
// Expected Fibonacci values are hand-computed constants.
module tb_fib_request_scheduler;

  localparam int N_REQ = 2;
  localparam int W     = 16;
  localparam int IDX_W = 6;

  logic                     clk;
  logic                     rst;
  logic [N_REQ-1:0]         req_valid;
  logic [N_REQ*IDX_W-1:0]   req_index;
  logic [N_REQ-1:0]         req_ready;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [W-1:0]             rsp_data;
  logic [$clog2(N_REQ)-1:0] rsp_id;
  logic                     rsp_overflow;
  logic                     busy;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [W-1:0] exp_q[$];   // expected grant ids, in order
  logic [W-1:0] id_q[$];    // ids granted, awaiting their responses

  fib_request_scheduler #(.N_REQ(N_REQ), .W(W), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_index(req_index), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_id(rsp_id), .rsp_overflow(rsp_overflow), .busy(busy)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request from requester id (rsp_ready assumed high), measure
  // latency from the accept cycle to rsp_valid, check the response.
  task automatic run_req(input int id, input int n, input logic [W-1:0] exp_d,
                         input logic exp_o, input int exp_lat, input string tag);
    int waitc;
    int lat;
    req_valid[id] = 1'b1;
    req_index[id*IDX_W +: IDX_W] = IDX_W'(n);
    #1;
    waitc = 0;
    while (!req_ready[id] && waitc < 50) begin
      tick();
      waitc++;
    end
    check({tag, "_accept"}, {31'd0, req_ready[id]}, 32'd1);
    tick();
    req_valid[id] = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 200) begin
      tick();
      lat++;
    end
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_data"}, {16'd0, rsp_data}, {16'd0, exp_d});
    check({tag, "_id"}, {31'd0, rsp_id}, id);
    check({tag, "_ovf"}, {31'd0, rsp_overflow}, {31'd0, exp_o});
    tick();
    check({tag, "_busy_after"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int grants;
    int resps;
    int gid;
    int waitc;

    // Reset with a request already pending: no grant on the reset cycle.
    rst       = 1'b1;
    req_valid = '0;
    req_index = '0;
    rsp_ready = 1'b1;
    req_valid[0] = 1'b1;
    req_index[0 +: IDX_W] = IDX_W'(10);
    tick();
    check("rst_ready", {30'd0, req_ready}, 32'd0);
    tick();
    check("rst_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_data", {16'd0, rsp_data}, 32'd0);
    check("rst_id", {31'd0, rsp_id}, 32'd0);
    check("rst_ovf", {31'd0, rsp_overflow}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    req_valid = '0;
    rst = 1'b0;
    tick();

    // Basic function and latency
    run_req(0, 10, 16'd55, 1'b0, 11, "n10");
    run_req(1, 0, 16'd0, 1'b0, 1, "n0");
    run_req(1, 1, 16'd1, 1'b0, 2, "n1");
    run_req(1, 2, 16'd1, 1'b0, 3, "n2");
    run_req(0, 24, 16'd46368, 1'b0, 25, "n24");
    run_req(0, 25, 16'd9489, 1'b1, 26, "n25");
    // Largest index: F(63) = 6557470319842, mod 65536 = 25826.
    run_req(1, 63, 16'd25826, 1'b1, 64, "n63");

    // Both requesters held valid with n=3: pointer is 0, grants alternate.
    exp_q = {16'd0, 16'd1, 16'd0, 16'd1};
    id_q.delete();
    req_index = {IDX_W'(3), IDX_W'(3)};
    req_valid = 2'b11;
    grants = 0;
    resps  = 0;
    for (int cyc = 0; cyc < 100 && resps < 4; cyc++) begin
      #1;
      check("arb_onehot", {31'd0, ($countones(req_ready) <= 1)}, 32'd1);
      if (|req_ready) begin
        gid = req_ready[1] ? 1 : 0;
        if (exp_q.size() > 0) check("arb_grant", gid, {16'd0, exp_q.pop_front()});
        else check("arb_extra_grant", gid, 32'hffff_ffff);
        id_q.push_back(W'(gid));
        grants++;
      end
      if (rsp_valid) begin
        if (id_q.size() > 0) check("arb_rsp_id", {31'd0, rsp_id}, {16'd0, id_q.pop_front()});
        else check("arb_orphan_rsp", {31'd0, rsp_id}, 32'hffff_ffff);
        check("arb_rsp_data", {16'd0, rsp_data}, 32'd2);
        resps++;
      end
      tick();
      if (grants >= 4) req_valid = '0;
    end
    req_valid = '0;
    check("arb_resp_count", resps, 4);

    // Back-pressure: response held 5 cycles, no grants while it waits.
    rsp_ready = 1'b0;
    req_valid[0] = 1'b1;
    req_index[0 +: IDX_W] = IDX_W'(3);
    #1;
    check("stall_accept", {31'd0, req_ready[0]}, 32'd1);
    tick();
    req_valid[0] = 1'b0;
    waitc = 0;
    while (!rsp_valid && waitc < 50) begin
      tick();
      waitc++;
    end
    req_valid[1] = 1'b1;
    req_index[IDX_W +: IDX_W] = IDX_W'(7);
    for (int i = 0; i < 5; i++) begin
      #1;
      check("stall_valid", {31'd0, rsp_valid}, 32'd1);
      check("stall_data", {16'd0, rsp_data}, 32'd2);
      check("stall_id", {31'd0, rsp_id}, 32'd0);
      check("stall_ready", {30'd0, req_ready}, 32'd0);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    check("stall_idle_busy", {31'd0, busy}, 32'd0);
    check("stall_idle_valid", {31'd0, rsp_valid}, 32'd0);
    check("stall_idle_grant", {30'd0, req_ready}, 32'd2);
    req_valid = '0;
    #1;

    // Reset in the middle of a long computation.
    tick();
    req_valid[0] = 1'b1;
    req_index[0 +: IDX_W] = IDX_W'(40);
    #1;
    check("mid_accept", {31'd0, req_ready[0]}, 32'd1);
    tick();
    req_valid[0] = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("mid_busy_before", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    tick();
    check("mid_rst_valid", {31'd0, rsp_valid}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_data", {16'd0, rsp_data}, 32'd0);
    check("mid_rst_id", {31'd0, rsp_id}, 32'd0);
    check("mid_rst_ovf", {31'd0, rsp_overflow}, 32'd0);
    rst = 1'b0;
    tick();
    run_req(1, 5, 16'd5, 1'b0, 6, "post_rst_n5");
`ifdef FIB_LAST_CACHE_EN
    run_req(1, 5, 16'd5, 1'b0, 1, "repeat_n5");
`else
    run_req(1, 5, 16'd5, 1'b0, 6, "repeat_n5");
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
